// File: rtl/core_pkg.sv
// Shared core types for the memory stage: FSM states, RV32I load/store encodings
// and the data-memory request/response records.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic        valid;
  } memory_io_req;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        valid;
  } memory_io_rsp;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-to-memory-stage handshake: one load/store offered per lsu_valid && lsu_ready.
interface load_store_unit_if;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_is_load;
  logic        lsu_is_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_store_data;
  logic [4:0]  lsu_rd;

  modport master (
    output lsu_valid, lsu_is_load, lsu_is_store, lsu_funct3, lsu_addr, lsu_store_data, lsu_rd,
    input  lsu_ready
  );

  modport slave (
    input  lsu_valid, lsu_is_load, lsu_is_store, lsu_funct3, lsu_addr, lsu_store_data, lsu_rd,
    output lsu_ready
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational access decode: legality, byte-lane mask, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_mask,
  output logic [31:0] store_wdata,
  output logic [31:0] load_value,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
    byte_mask   = 4'b1111;
    store_wdata = store_data;
    load_value  = '0;
    illegal     = 1'b1;
    misaligned  = 1'b0;
    shifted     = load_word >> {addr_lo, 3'b000};

    // funct3[1:0] carries the access size for both loads and stores.
    case (funct3[1:0])
      2'b00: begin
        byte_mask   = 4'b0001 << addr_lo;
        store_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        byte_mask   = 4'b0011 << addr_lo;
        store_wdata = {2{store_data[15:0]}};
        misaligned  = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase

    case (funct3)
      F3_LB:   load_value = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_value = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_value = {24'h0, shifted[7:0]};
      F3_LHU:  load_value = {16'h0, shifted[15:0]};
      default: load_value = shifted;
    endcase

    if (is_load == is_store)
      illegal = 1'b1;
    else if (is_load)
      illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    else
      illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the multicycle RV32I core: accepts one load/store, issues a single
// data-memory request, and returns a one-cycle writeback packet.
module load_store_unit
  import core_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    bus,
  output memory_io_req        data_mem_req,
  input  memory_io_rsp        data_mem_rsp,
  output logic                wb_valid,
  output logic                wb_write_enable,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                err_misaligned,
  output logic                err_illegal,
  output logic                err_timeout
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_addr_lo;
  logic             lat_is_load;
  logic [4:0]       lat_rd;

  logic [2:0]  align_funct3;
  logic [1:0]  align_addr_lo;
  logic [3:0]  byte_mask;
  logic [31:0] store_wdata;
  logic [31:0] load_value;
  logic        illegal;
  logic        misaligned;

  // The response address is not needed: only one request is ever outstanding.
  logic unused_rsp_addr;
  assign unused_rsp_addr = ^data_mem_rsp.addr;

  // Decode the live inputs while accepting, the latched copy afterwards.
  assign align_funct3  = (state == ST_IDLE) ? bus.lsu_funct3   : lat_funct3;
  assign align_addr_lo = (state == ST_IDLE) ? bus.lsu_addr[1:0] : lat_addr_lo;

  lsu_align u_align (
    .is_load     (bus.lsu_is_load),
    .is_store    (bus.lsu_is_store),
    .funct3      (align_funct3),
    .addr_lo     (align_addr_lo),
    .store_data  (bus.lsu_store_data),
    .load_word   (data_mem_rsp.data),
    .byte_mask   (byte_mask),
    .store_wdata (store_wdata),
    .load_value  (load_value),
    .illegal     (illegal),
    .misaligned  (misaligned)
  );

  // NOTE: all state is updated with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.lsu_ready   <= 1'b1;
      data_mem_req    <= '0;
      wb_valid        <= 1'b0;
      wb_write_enable <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      err_misaligned  <= 1'b0;
      err_illegal     <= 1'b0;
      err_timeout     <= 1'b0;
      wait_cnt        <= '0;
      lat_funct3      <= '0;
      lat_addr_lo     <= '0;
      lat_is_load     <= 1'b0;
      lat_rd          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.lsu_valid) begin
            lat_funct3    <= bus.lsu_funct3;
            lat_addr_lo   <= bus.lsu_addr[1:0];
            lat_is_load   <= bus.lsu_is_load;
            lat_rd        <= bus.lsu_rd;
            bus.lsu_ready <= 1'b0;
            if (illegal || misaligned) begin
              err_illegal     <= err_illegal | illegal;
              err_misaligned  <= err_misaligned | (misaligned & ~illegal);
              wb_valid        <= 1'b1;
              wb_write_enable <= 1'b0;
              wb_rd           <= bus.lsu_rd;
              state           <= ST_DONE;
            end else begin
              data_mem_req.addr     <= {bus.lsu_addr[31:2], 2'b00};
              data_mem_req.data     <= bus.lsu_is_load ? 32'h0 : store_wdata;
              data_mem_req.do_read  <= bus.lsu_is_load ? byte_mask : 4'b0000;
              data_mem_req.do_write <= bus.lsu_is_load ? 4'b0000 : byte_mask;
              data_mem_req.valid    <= 1'b1;
              state                 <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          data_mem_req <= '0;
          wait_cnt     <= '0;
          if (lat_is_load) begin
            state <= ST_WAIT;
          end else begin
            wb_valid        <= 1'b1;
            wb_write_enable <= 1'b0;
            wb_rd           <= lat_rd;
            state           <= ST_DONE;
          end
        end

        ST_WAIT: begin
          if (data_mem_rsp.valid) begin
            wb_valid        <= 1'b1;
            wb_write_enable <= (lat_rd != 5'd0);
            wb_rd           <= lat_rd;
            wb_data         <= load_value;
            state           <= ST_DONE;
          end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
            err_timeout     <= 1'b1;
            wb_valid        <= 1'b1;
            wb_write_enable <= 1'b0;
            wb_rd           <= lat_rd;
            state           <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          wb_valid        <= 1'b0;
          wb_write_enable <= 1'b0;
          bus.lsu_ready   <= 1'b1;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads with extension, error paths,
// timeout and reset during an outstanding load.
module tb_load_store_unit;
  import core_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  memory_io_req data_mem_req;
  memory_io_rsp data_mem_rsp;
  logic         wb_valid;
  logic         wb_write_enable;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         err_misaligned;
  logic         err_illegal;
  logic         err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.WAIT_LIMIT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave),
    .data_mem_req    (data_mem_req),
    .data_mem_rsp    (data_mem_rsp),
    .wb_valid        (wb_valid),
    .wb_write_enable (wb_write_enable),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .err_misaligned  (err_misaligned),
    .err_illegal     (err_illegal),
    .err_timeout     (err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one access in the current cycle; returns in the cycle after the accept edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    int n = 0;
    while (bus.lsu_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: lsu_ready=%b expected 1 (waited %0d cycles)", bus.lsu_ready, n);
    end
    bus.lsu_valid      = 1'b1;
    bus.lsu_is_load    = ld;
    bus.lsu_is_store   = st;
    bus.lsu_funct3     = f3;
    bus.lsu_addr       = addr;
    bus.lsu_store_data = sd;
    bus.lsu_rd         = rd;
    step();
    bus.lsu_valid = 1'b0;
  endtask

  task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_mask, input logic [31:0] exp_data);
    issue(1'b0, 1'b1, f3, addr, sd, 5'd9);
    checks++;
    if (data_mem_req !== '{exp_addr, exp_data, 4'b0000, exp_mask, 1'b1}) begin
      errors++;
      $display("FAIL %s_req: got addr=%h data=%h rd=%b wr=%b v=%b expected addr=%h data=%h rd=0000 wr=%b v=1",
               name, data_mem_req.addr, data_mem_req.data, data_mem_req.do_read,
               data_mem_req.do_write, data_mem_req.valid, exp_addr, exp_data, exp_mask);
    end
    step();
    checks++;
    if ({wb_valid, wb_write_enable, data_mem_req.valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s_wb: wb_valid/we/req_valid=%b expected 100", name,
               {wb_valid, wb_write_enable, data_mem_req.valid});
    end
    step();
    checks++;
    if ({wb_valid, bus.lsu_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s_idle: wb_valid/ready=%b expected 01", name, {wb_valid, bus.lsu_ready});
    end
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rsp_word,
                         input logic [3:0] exp_mask, input logic [31:0] exp_data,
                         input logic exp_we);
    issue(1'b1, 1'b0, f3, addr, 32'h0, rd);
    checks++;
    if ({data_mem_req.valid, data_mem_req.addr, data_mem_req.do_read, data_mem_req.do_write} !==
        {1'b1, {addr[31:2], 2'b00}, exp_mask, 4'b0000}) begin
      errors++;
      $display("FAIL %s_req: got v=%b addr=%h rd=%b wr=%b expected v=1 rd=%b wr=0000",
               name, data_mem_req.valid, data_mem_req.addr, data_mem_req.do_read,
               data_mem_req.do_write, exp_mask);
    end
    step();
    checks++;
    if ({wb_valid, data_mem_req.valid} !== 2'b00) begin
      errors++;
      $display("FAIL %s_wait: wb_valid/req_valid=%b expected 00", name, {wb_valid, data_mem_req.valid});
    end
    data_mem_rsp = '{32'h0, rsp_word, 1'b1};
    step();
    data_mem_rsp.valid = 1'b0;
    checks++;
    if ({wb_valid, wb_write_enable, wb_rd, wb_data} !== {1'b1, exp_we, rd, exp_data}) begin
      errors++;
      $display("FAIL %s_wb: got v=%b we=%b rd=%0d data=%h expected v=1 we=%b rd=%0d data=%h",
               name, wb_valid, wb_write_enable, wb_rd, wb_data, exp_we, rd, exp_data);
    end
    step();
    checks++;
    if ({wb_valid, wb_write_enable, bus.lsu_ready} !== 3'b001) begin
      errors++;
      $display("FAIL %s_idle: wb_valid/we/ready=%b expected 001", name,
               {wb_valid, wb_write_enable, bus.lsu_ready});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if ({bus.lsu_ready, data_mem_req, wb_valid, wb_write_enable, wb_rd, wb_data,
         err_misaligned, err_illegal, err_timeout} !== {1'b1, 73'h0, 1'b0, 1'b0, 5'd0, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: ready=%b req=%h wb_v=%b we=%b rd=%0d data=%h err=%b%b%b expected ready=1 rest 0",
               bus.lsu_ready, data_mem_req, wb_valid, wb_write_enable, wb_rd, wb_data,
               err_misaligned, err_illegal, err_timeout);
    end
  endtask

  task automatic test_stores();
    do_store("sw", F3_SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    do_store("sb", F3_SB, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", F3_SH, 32'h0000_0342, 32'h1234_BEEF, 32'h0000_0340, 4'b1100, 32'hBEEF_BEEF);
  endtask

  task automatic test_loads();
    do_load("lb",  F3_LB,  32'h0000_0102, 5'd5,  32'h1280_3456, 4'b0100, 32'hFFFF_FF80, 1'b1);
    checks++;
    if (wb_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL wb_data_hold: got %h expected ffffff80", wb_data);
    end
    do_load("lbu", F3_LBU, 32'h0000_0102, 5'd5,  32'h1280_3456, 4'b0100, 32'h0000_0080, 1'b1);
    do_load("lh",  F3_LH,  32'h0000_0082, 5'd11, 32'h8001_1234, 4'b1100, 32'hFFFF_8001, 1'b1);
    do_load("lhu", F3_LHU, 32'h0000_0080, 5'd12, 32'h1234_9ABC, 4'b0011, 32'h0000_9ABC, 1'b1);
    do_load("lw",  F3_LW,  32'h0000_0204, 5'd31, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b1);
    do_load("lw_rd0", F3_LW, 32'h0000_0208, 5'd0, 32'h1111_2222, 4'b1111, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, F3_LH, 32'h0000_0101, 32'h0, 5'd3);
    checks++;
    if ({data_mem_req.valid, wb_valid, wb_write_enable, err_misaligned, err_illegal} !== 5'b01010) begin
      errors++;
      $display("FAIL misaligned_lh: req_v/wb_v/we/err_mis/err_ill=%b expected 01010",
               {data_mem_req.valid, wb_valid, wb_write_enable, err_misaligned, err_illegal});
    end
    step();
    do_load("lw_after_mis", F3_LW, 32'h0000_0200, 5'd7, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b1);
    issue(1'b0, 1'b1, F3_SW, 32'h0000_0102, 32'h0, 5'd0);
    checks++;
    if ({data_mem_req.valid, wb_valid, err_misaligned} !== 3'b011) begin
      errors++;
      $display("FAIL misaligned_sw: req_v/wb_v/err_mis=%b expected 011",
               {data_mem_req.valid, wb_valid, err_misaligned});
    end
    step();
  endtask

  task automatic test_illegal();
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd4);
    checks++;
    if ({data_mem_req.valid, wb_valid, wb_write_enable, err_illegal} !== 4'b0101) begin
      errors++;
      $display("FAIL illegal_f3: req_v/wb_v/we/err_ill=%b expected 0101",
               {data_mem_req.valid, wb_valid, wb_write_enable, err_illegal});
    end
    step();
    issue(1'b1, 1'b1, F3_LW, 32'h0000_0100, 32'h0, 5'd4);
    checks++;
    if ({data_mem_req.valid, wb_valid, err_illegal} !== 3'b011) begin
      errors++;
      $display("FAIL illegal_both: req_v/wb_v/err_ill=%b expected 011",
               {data_mem_req.valid, wb_valid, err_illegal});
    end
    step();
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd4);
    checks++;
    if ({data_mem_req.valid, wb_valid} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_store_f3: req_v/wb_v=%b expected 01", {data_mem_req.valid, wb_valid});
    end
    step();
  endtask

  task automatic test_stray_rsp();
    data_mem_rsp = '{32'h0, 32'h5555_5555, 1'b1};
    step();
    data_mem_rsp.valid = 1'b0;
    checks++;
    if ({wb_valid, bus.lsu_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stray_rsp: wb_valid/ready=%b expected 01", {wb_valid, bus.lsu_ready});
    end
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    issue(1'b1, 1'b0, F3_LW, 32'h0000_0300, 32'h0, 5'd6);
    for (int i = 0; i < 16; i++) begin
      step();
      if (wb_valid !== 1'b0 || err_timeout !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: wb_valid or err_timeout rose within 16 WAIT cycles (got 1, expected 0)");
    end
    step();
    checks++;
    if ({wb_valid, wb_write_enable, err_timeout} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_done: wb_v/we/err_to=%b expected 101", {wb_valid, wb_write_enable, err_timeout});
    end
    step();
    checks++;
    if ({bus.lsu_ready, err_timeout} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_ready: ready/err_to=%b expected 11", {bus.lsu_ready, err_timeout});
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, F3_LW, 32'h0000_0400, 32'h0, 5'd8);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    data_mem_rsp = '{32'h0000_0400, 32'h7777_7777, 1'b1};
    checks++;
    if ({bus.lsu_ready, data_mem_req, wb_valid, wb_write_enable, err_misaligned, err_illegal, err_timeout} !==
        {1'b1, 73'h0, 5'b00000}) begin
      errors++;
      $display("FAIL reset_mid: ready=%b req=%h wb_v=%b we=%b err=%b%b%b expected ready=1 rest 0",
               bus.lsu_ready, data_mem_req, wb_valid, wb_write_enable,
               err_misaligned, err_illegal, err_timeout);
    end
    step();
    data_mem_rsp.valid = 1'b0;
    checks++;
    if ({wb_valid, bus.lsu_ready, wb_data} !== {2'b01, 32'h0}) begin
      errors++;
      $display("FAIL reset_rsp_ignored: wb_v/ready=%b data=%h expected 01 data=00000000",
               {wb_valid, bus.lsu_ready}, wb_data);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.lsu_valid      = 1'b0;
    bus.lsu_is_load    = 1'b0;
    bus.lsu_is_store   = 1'b0;
    bus.lsu_funct3     = '0;
    bus.lsu_addr       = '0;
    bus.lsu_store_data = '0;
    bus.lsu_rd         = '0;
    data_mem_rsp       = '0;
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_illegal();
    test_stray_rsp();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
